// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types for the GPR writeback arbiter: register index, data word and
// the per-requester writeback request bundle.
package gpr_wb_arbiter_pkg;

    localparam int GPR_COUNT = 32;

    typedef logic [31:0] Word;
    typedef logic [4:0]  Reg_index;

    typedef struct packed {
        Reg_index sel;
        Word      data;
    } Gpr_wb_req;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Writeback bus between the execution units / issue logic (master) and the
// GPR writeback arbiter (slave).
interface gpr_wb_arbiter_if
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) ();

    logic [NUM_REQ-1:0]      req_valid;
    Gpr_wb_req [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0]      req_ready;

    logic                    wa_wr;
    Reg_index                wa_sel;
    Word                     wa;

    logic                    reserve_valid;
    Reg_index                reserve_sel;
    logic [GPR_COUNT-1:0]    busy;
    logic                    err_double_reserve;

    modport master (
        output req_valid, req, reserve_valid, reserve_sel,
        input  req_ready, wa_wr, wa_sel, wa, busy, err_double_reserve
    );

    modport slave (
        input  req_valid, req, reserve_valid, reserve_sel,
        output req_ready, wa_wr, wa_sel, wa, busy, err_double_reserve
    );

endinterface

// File: rtl/gpr_wb_arbiter_rr.sv
// One-hot grant picker: round-robin starting after the last winner, or fixed
// priority with index 0 highest.
module rr_arbiter #(
    parameter int N          = 3,
    parameter bit FIXED_PRIO = 1'b0,
    parameter int PW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  valid_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] gidx_o,
    output logic          gnt_o
);

    logic [PW-1:0] ptr_q;
    int            idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        gidx_o  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            if (FIXED_PRIO) idx = k;
            else            idx = (int'(ptr_q) + 1 + k) % N;
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                gidx_o       = PW'(idx);
                found        = 1'b1;
            end
        end
        gnt_o = found;
    end

    // Pointer parks at N-1 so the first search after reset starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      ptr_q <= PW'(N - 1);
        else if (gnt_o) ptr_q <= gidx_o;
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port among NUM_REQ writeback units through a
// registered output stage, and tracks outstanding destinations in a scoreboard.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    gpr_wb_arbiter_if.slave  wb
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        gidx;
    logic                 gnt;

    logic                 wa_wr_q;
    Reg_index             wa_sel_q;
    Word                  wa_q;
    logic [GPR_COUNT-1:0] busy_q, busy_d;
    logic                 err_q, err_d;

    rr_arbiter #(
        .N          (NUM_REQ),
        .FIXED_PRIO (FIXED_PRIO),
        .PW         (PW)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_i (wb.req_valid),
        .grant_o (grant),
        .gidx_o  (gidx),
        .gnt_o   (gnt)
    );

    // Output stage never stalls, so the grant is the handshake.
    assign wb.req_ready = reset ? '0 : grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wa_wr_q  <= 1'b0;
            wa_sel_q <= '0;
            wa_q     <= '0;
        end else begin
            wa_wr_q <= gnt;
            if (gnt) begin
                wa_sel_q <= wb.req[gidx].sel;
                wa_q     <= wb.req[gidx].data;
            end
        end
    end

    // Clear on commit first, then set on reserve so a same-cycle reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (wa_wr_q)          busy_d[wa_sel_q]       = 1'b0;
        if (wb.reserve_valid) busy_d[wb.reserve_sel] = 1'b1;
        err_d = wb.reserve_valid && busy_q[wb.reserve_sel] &&
                !(wa_wr_q && (wa_sel_q == wb.reserve_sel));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign wb.wa_wr              = wa_wr_q;
    assign wb.wa_sel             = wa_sel_q;
    assign wb.wa                 = wa_q;
    assign wb.busy               = busy_q;
    assign wb.err_double_reserve = err_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter, both NUM_REQ=3.
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    gpr_wb_arbiter_if #(.NUM_REQ(3)) rr_if ();
    gpr_wb_arbiter_if #(.NUM_REQ(3)) fp_if ();

    gpr_wb_arbiter #(.NUM_REQ(3), .FIXED_PRIO(1'b0)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .wb    (rr_if.slave)
    );

    gpr_wb_arbiter #(.NUM_REQ(3), .FIXED_PRIO(1'b1)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .wb    (fp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester obligation: payload holds while waiting for a grant.
    for (genvar i = 0; i < 3; i++) begin : g_stable
        assert property (@(posedge clk) disable iff (reset)
            (rr_if.req_valid[i] && !rr_if.req_ready[i]) |=>
            (!rr_if.req_valid[i] || $stable(rr_if.req[i])));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rr_if.req_valid = '0; rr_if.req = '0;
        rr_if.reserve_valid = 1'b0; rr_if.reserve_sel = '0;
        fp_if.req_valid = '0; fp_if.req = '0;
        fp_if.reserve_valid = 1'b0; fp_if.reserve_sel = '0;

        // Reset state; ready forced low even with a valid request
        rr_if.req_valid = 3'b001;
        rr_if.req[0].sel = 5'd5;
        rr_if.req[0].data = 32'hDEADBEEF;
        #2;
        chk("rst_ready", rr_if.req_ready, 3'b000);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_wa_wr", rr_if.wa_wr, 0);
        chk("rst_wa_sel", rr_if.wa_sel, 0);
        chk("rst_wa", rr_if.wa, 0);
        chk("rst_busy", rr_if.busy, 0);
        chk("rst_err", rr_if.err_double_reserve, 0);

        // Single request: grant in t, commit in t+1
        chk("t1_ready", rr_if.req_ready, 3'b001);
        tick();
        rr_if.req_valid = 3'b000;
        chk("t1_wa_wr", rr_if.wa_wr, 1);
        chk("t1_wa_sel", rr_if.wa_sel, 5);
        chk("t1_wa", rr_if.wa, 32'hDEADBEEF);
        #1;
        chk("t1_idle_ready", rr_if.req_ready, 3'b000);
        tick();
        chk("t1_idle_wa_wr", rr_if.wa_wr, 0);

        // Round-robin from a fresh pointer: 0,1,2,0,1,2
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rr_if.req[i].sel = 5'(10 + i);
            rr_if.req[i].data = 32'hA000_0000 + 32'(i);
        end
        rr_if.req_valid = 3'b111;
        tick();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk("rr_ready", rr_if.req_ready, 3'b001 << (c % 3));
            tick();
            chk("rr_wa_wr", rr_if.wa_wr, 1);
            chk("rr_wa_sel", rr_if.wa_sel, 10 + (c % 3));
            chk("rr_wa", rr_if.wa, 32'hA000_0000 + 32'(c % 3));
            #1;
        end
        rr_if.req_valid = 3'b000;
        tick();
        chk("rr_drain_wa_wr", rr_if.wa_wr, 0);

        // Fixed priority: requester 2 starves behind 0
        fp_if.req[0].sel = 5'd1; fp_if.req[0].data = 32'h1111;
        fp_if.req[2].sel = 5'd3; fp_if.req[2].data = 32'h3333;
        fp_if.req_valid = 3'b101;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("fp_ready", fp_if.req_ready, 3'b001);
            tick();
            chk("fp_wa_sel", fp_if.wa_sel, 1);
            chk("fp_wa", fp_if.wa, 32'h1111);
        end
        fp_if.req_valid = 3'b100;
        #1;
        chk("fp_ready_2", fp_if.req_ready, 3'b100);
        tick();
        fp_if.req_valid = 3'b000;
        chk("fp_wa_sel_2", fp_if.wa_sel, 3);

        // Reserve 7, then commit 7 with a same-cycle re-reserve of 7
        rr_if.reserve_valid = 1'b1; rr_if.reserve_sel = 5'd7;
        tick();
        rr_if.reserve_valid = 1'b0;
        chk("res7_busy", rr_if.busy, 32'h0000_0080);
        chk("res7_err", rr_if.err_double_reserve, 0);
        rr_if.req[0].sel = 5'd7; rr_if.req[0].data = 32'h7777;
        rr_if.req_valid = 3'b001;
        tick();
        rr_if.req_valid = 3'b000;
        chk("c7_wa_wr", rr_if.wa_wr, 1);
        chk("c7_wa_sel", rr_if.wa_sel, 7);
        rr_if.reserve_valid = 1'b1; rr_if.reserve_sel = 5'd7;
        tick();
        rr_if.reserve_valid = 1'b0;
        chk("c7_setwins_busy", rr_if.busy, 32'h0000_0080);
        chk("c7_setwins_err", rr_if.err_double_reserve, 0);
        // Plain commit releases 7
        rr_if.req_valid = 3'b001;
        tick();
        rr_if.req_valid = 3'b000;
        tick();
        chk("c7_release_busy", rr_if.busy, 0);

        // Double reserve of 9
        rr_if.reserve_valid = 1'b1; rr_if.reserve_sel = 5'd9;
        tick();
        chk("r9a_busy", rr_if.busy, 32'h0000_0200);
        chk("r9a_err", rr_if.err_double_reserve, 0);
        tick();
        rr_if.reserve_valid = 1'b0;
        chk("r9b_busy", rr_if.busy, 32'h0000_0200);
        chk("r9b_err", rr_if.err_double_reserve, 1);
        tick();
        chk("r9c_err", rr_if.err_double_reserve, 0);
        chk("r9c_busy", rr_if.busy, 32'h0000_0200);

        // Async reset while a write is on the port
        rr_if.req[0].sel = 5'd20; rr_if.req[0].data = 32'hA5A5_A5A5;
        rr_if.req_valid = 3'b001;
        tick();
        chk("ar_pre_wa_wr", rr_if.wa_wr, 1);
        chk("ar_pre_wa_sel", rr_if.wa_sel, 20);
        rr_if.req_valid = 3'b111;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_wa_wr", rr_if.wa_wr, 0);
        chk("ar_busy", rr_if.busy, 0);
        chk("ar_ready", rr_if.req_ready, 3'b000);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_rel_ready", rr_if.req_ready, 3'b001);
        tick();
        chk("ar_rel_wa_wr", rr_if.wa_wr, 1);
        chk("ar_rel_wa_sel", rr_if.wa_sel, 20);
        chk("ar_next_ready", rr_if.req_ready, 3'b010);
        rr_if.req_valid = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the GPR file's single write port (wa_wr/wa_sel/wa) between NUM_REQ writeback requesters, e.g. ALU, load unit and mul/div.
- Arbitration is round-robin or fixed-priority, with a registered output stage.
- Maintains a 32-bit busy scoreboard: issue reserves a destination GPR; the write-port commit releases it.
- Sits between the execution units and Gpr_file; the issue logic reads busy for hazard stalls.

Parameters:
- NUM_REQ, 3: number of writeback requesters (2..8).
- FIXED_PRIO, 1'b0: 0 = round-robin; 1 = fixed priority, index 0 highest.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  requester i has a write pending
- req_sel  in  NUM_REQ x 5  destination GPR index per requester (Reg_index)
- req_data  in  NUM_REQ x 32  write data per requester (Word)
- req_ready  out  NUM_REQ  grant; handshake = req_valid[i] && req_ready[i]
- wa_wr  out  1  GPR write enable
- wa_sel  out  5  GPR write index
- wa  out  32  GPR write data
- reserve_valid  in  1  issue reserves a destination register this cycle
- reserve_sel  in  5  index to reserve
- busy  out  32  scoreboard; bit n = GPR n has an outstanding write
- err_double_reserve  out  1  one-cycle pulse: reserve hit an already-busy register

Behaviour:
- Reset: asynchronous, active-high. While asserted and after release:
  - wa_wr=0, wa_sel=0, wa=0, busy=0, err_double_reserve=0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - req_ready forced 0 while reset is high.
- Reset mid-operation drops any registered write (wa_wr deasserted) and clears all reservations; no partial write may reach the GPR file.
- Grant (combinational in cycle t):
  - At most one req_ready bit high per cycle, and only for a requester with req_valid=1.
  - req_ready never depends on another requester's ready.
  - The output stage always accepts, so one grant per cycle whenever any valid is high.
- Round-robin: search order starts at pointer+1 mod NUM_REQ and wraps. The pointer loads the granted index on grant and holds when nothing is granted.
- Fixed priority: lowest asserted index wins. Starvation of higher indices is permitted.
- Requester obligation: req_sel/req_data stay stable while req_valid is high and not yet granted. The bench asserts this.
- Output stage (registered):
  - A grant in cycle t drives wa_wr=1, wa_sel=req_sel[g], wa=req_data[g] in cycle t+1.
  - With no grant, wa_wr=0 in t+1. wa_sel/wa hold their last values; they are don't-care when wa_wr=0.
  - Latency: request to GPR write commit = 1 cycle from grant; the register is updated at the edge ending t+1.
  - GPR-file bypass makes the data visible to a read select registered in t+1.
- Scoreboard, at each clock edge:
  - Clear busy[wa_sel] if wa_wr=1.
  - Set busy[reserve_sel] if reserve_valid=1.
  - Same index set and clear in the same cycle: set wins, and busy stays 1 for the new reservation.
  - Reserve on an already-busy index with no clear in that cycle: bit stays 1 and err_double_reserve pulses for one cycle (registered).
  - Commit to a non-busy register: legal (untracked writer); no state change.
- No write is ever lost or duplicated. Each handshake produces exactly one wa_wr cycle.

Decomposition:
- Pu_types package: reuse Word and Reg_index; add constant GPR_COUNT=32.
- New typedef Gpr_wb_req: a packed struct of sel and data. The port arrays use it.
- Sub-module rr_arbiter (params N, FIXED_PRIO): valid vector in, one-hot grant out, internal pointer, async reset.
- Output register and scoreboard stay in gpr_wb_arbiter.

Test Plan:
- After reset release, busy=0 and wa_wr=0. req_valid=3'b001, req_sel[0]=5, req_data[0]=32'hDEADBEEF → req_ready=3'b001 in t; wa_wr=1, wa_sel=5, wa=32'hDEADBEEF in t+1.
- Round-robin, all three valid continuously for 6 cycles → grant sequence 0,1,2,0,1,2. wa_sel follows req_sel in order, one cycle delayed.
- FIXED_PRIO=1, req 0 and 2 valid for 3 cycles → req 0 granted every cycle; req 2 never granted while req 0 stays valid.
- reserve_valid=1, reserve_sel=7 → busy[7]=1 next cycle. Later a commit with wa_sel=7 coinciding with reserve_sel=7 → busy[7] stays 1 and err_double_reserve=0.
- Reserve 9 twice with no intervening commit → err_double_reserve pulses for exactly 1 cycle; busy[9]=1.
- Async reset asserted mid-cycle while wa_wr=1 → wa_wr=0, busy=0 and req_ready=0 immediately. After release, the pending request is re-granted starting from requester 0.
